// File: rtl/exec_ctrl_datapath.sv
// Execute-stage core of the single-cycle MIPS CPU: opcode decode, 32-bit ALU,
// word-addressed data memory and the register write-back mux.
module exec_ctrl_datapath #(
  parameter int unsigned MEM_DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [31:0] read_data1,
  input  logic [31:0] read_data2,
  input  logic [31:0] imm_ext,
  output logic        pc_wre,
  output logic        alu_src_b,
  output logic        alu_m2reg,
  output logic        reg_wre,
  output logic        ins_mem_rw,
  output logic        data_mem_rw,
  output logic        ext_sel,
  output logic        pc_src,
  output logic        reg_out,
  output logic [2:0]  alu_op,
  output logic        zero,
  output logic [31:0] result,
  output logic [31:0] write_data
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);

  localparam logic [5:0] OpAdd  = 6'b000000;
  localparam logic [5:0] OpAddi = 6'b000001;
  localparam logic [5:0] OpSub  = 6'b000010;
  localparam logic [5:0] OpOri  = 6'b010000;
  localparam logic [5:0] OpAnd  = 6'b010001;
  localparam logic [5:0] OpOr   = 6'b010010;
  localparam logic [5:0] OpMove = 6'b100000;
  localparam logic [5:0] OpSw   = 6'b100110;
  localparam logic [5:0] OpLw   = 6'b100111;
  localparam logic [5:0] OpBeq  = 6'b110000;
  localparam logic [5:0] OpHalt = 6'b111111;

  logic          pc_wre_dec;
  logic          reg_wre_dec;
  logic          mem_wr_dec;
  logic [31:0]   alu_b;
  logic [AW-1:0] mem_idx;
  logic [31:0]   mem_q [MEM_DEPTH];

  always_comb begin
    pc_wre_dec  = 1'b1;
    alu_src_b   = 1'b0;
    alu_m2reg   = 1'b0;
    reg_wre_dec = 1'b0;
    mem_wr_dec  = 1'b0;
    ext_sel     = 1'b0;
    reg_out     = 1'b0;
    alu_op      = 3'b000;
    case (opcode)
      OpAdd, OpMove: begin
        reg_wre_dec = 1'b1;
        ext_sel     = 1'b1;
        reg_out     = 1'b1;
      end
      OpAddi: begin
        alu_src_b   = 1'b1;
        reg_wre_dec = 1'b1;
        ext_sel     = 1'b1;
      end
      OpSub: begin
        reg_wre_dec = 1'b1;
        ext_sel     = 1'b1;
        reg_out     = 1'b1;
        alu_op      = 3'b001;
      end
      OpOri: begin
        alu_src_b   = 1'b1;
        reg_wre_dec = 1'b1;
        alu_op      = 3'b011;
      end
      OpAnd: begin
        reg_wre_dec = 1'b1;
        ext_sel     = 1'b1;
        reg_out     = 1'b1;
        alu_op      = 3'b100;
      end
      OpOr: begin
        reg_wre_dec = 1'b1;
        ext_sel     = 1'b1;
        reg_out     = 1'b1;
        alu_op      = 3'b011;
      end
      OpSw: begin
        alu_src_b  = 1'b1;
        mem_wr_dec = 1'b1;
        ext_sel    = 1'b1;
      end
      OpLw: begin
        alu_src_b   = 1'b1;
        alu_m2reg   = 1'b1;
        reg_wre_dec = 1'b1;
        ext_sel     = 1'b1;
      end
      OpBeq: begin
        ext_sel = 1'b1;
        alu_op  = 3'b001;
      end
      OpHalt: begin
        pc_wre_dec = 1'b0;
        ext_sel    = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset suppresses every state-changing strobe; the remaining decode stays live.
  assign pc_wre      = pc_wre_dec & ~rst;
  assign reg_wre     = reg_wre_dec & ~rst;
  assign data_mem_rw = mem_wr_dec & ~rst;
  assign pc_src      = (opcode == OpBeq) & zero & ~rst;
  assign ins_mem_rw  = 1'b1;

  assign alu_b = alu_src_b ? imm_ext : read_data2;

  always_comb begin
    result = '0;
    case (alu_op)
      3'b000: result = read_data1 + alu_b;
      3'b001: result = read_data1 - alu_b;
      3'b010: result = alu_b - read_data1;
      3'b011: result = read_data1 | alu_b;
      3'b100: result = read_data1 & alu_b;
      3'b101: result = ~read_data1 & alu_b;
      3'b110: result = read_data1 ^ alu_b;
      3'b111: result = read_data1 ~^ alu_b;
      default: result = '0;
    endcase
  end

  assign zero = (result == 32'd0);

  // Byte address -> word index; upper bits dropped so addresses wrap.
  assign mem_idx = result[AW+1:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(MEM_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (data_mem_rw) begin
      mem_q[mem_idx] <= read_data2;
    end
  end

  assign write_data = alu_m2reg ? mem_q[mem_idx] : result;

endmodule

// File: tb/tb_exec_ctrl_datapath.sv
// Scoreboard bench for exec_ctrl_datapath: directed vectors push expectations,
// a negedge monitor pops and compares against the live DUT outputs.
module tb_exec_ctrl_datapath;

  logic        clk;
  logic        rst;
  logic [5:0]  opcode;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic [31:0] imm_ext;
  logic        pc_wre;
  logic        alu_src_b;
  logic        alu_m2reg;
  logic        reg_wre;
  logic        ins_mem_rw;
  logic        data_mem_rw;
  logic        ext_sel;
  logic        pc_src;
  logic        reg_out;
  logic [2:0]  alu_op;
  logic        zero;
  logic [31:0] result;
  logic [31:0] write_data;

  exec_ctrl_datapath #(
    .MEM_DEPTH(64)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .read_data1 (read_data1),
    .read_data2 (read_data2),
    .imm_ext    (imm_ext),
    .pc_wre     (pc_wre),
    .alu_src_b  (alu_src_b),
    .alu_m2reg  (alu_m2reg),
    .reg_wre    (reg_wre),
    .ins_mem_rw (ins_mem_rw),
    .data_mem_rw(data_mem_rw),
    .ext_sel    (ext_sel),
    .pc_src     (pc_src),
    .reg_out    (reg_out),
    .alu_op     (alu_op),
    .zero       (zero),
    .result     (result),
    .write_data (write_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [12:0] ctrl;
    logic [31:0] res;
    logic [31:0] wd;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  logic vld;
  int   n_cmp;
  int   n_bad;

  // {pc_wre,alu_src_b,alu_m2reg,reg_wre,ins_mem_rw,data_mem_rw,ext_sel,pc_src,reg_out,alu_op,zero}
  logic [12:0] ctrl_obs;
  assign ctrl_obs = {pc_wre, alu_src_b, alu_m2reg, reg_wre, ins_mem_rw, data_mem_rw,
                     ext_sel, pc_src, reg_out, alu_op, zero};

  always @(negedge clk) begin
    if (vld) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard_empty: output presented with no expectation queued");
      end else begin
        mon_e = sb_q.pop_front();
        n_cmp++;
        if (ctrl_obs !== mon_e.ctrl) begin
          n_bad++;
          $display("FAIL %s ctrl: got %b want %b", mon_e.name, ctrl_obs, mon_e.ctrl);
        end
        n_cmp++;
        if (result !== mon_e.res || write_data !== mon_e.wd) begin
          n_bad++;
          $display("FAIL %s data: got result=%h write_data=%h want result=%h write_data=%h",
                   mon_e.name, result, write_data, mon_e.res, mon_e.wd);
        end
      end
    end
  end

  task automatic drive(input string nm, input logic r, input logic [5:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                       input logic [12:0] c, input logic [31:0] er, input logic [31:0] ew);
    exp_t e;
    @(posedge clk);
    #1;
    rst        = r;
    opcode     = op;
    read_data1 = a;
    read_data2 = b;
    imm_ext    = im;
    e.name = nm;
    e.ctrl = c;
    e.res  = er;
    e.wd   = ew;
    sb_q.push_back(e);
    vld = 1'b1;
  endtask

  initial begin
    vld        = 1'b0;
    n_cmp      = 0;
    n_bad      = 0;
    rst        = 1'b1;
    opcode     = 6'b000000;
    read_data1 = '0;
    read_data2 = '0;
    imm_ext    = '0;
    repeat (2) @(posedge clk);

    // Store attempted under reset: strobes low, memory cleared at the edge.
    drive("rst_sw", 1'b1, 6'b100110, 32'd8, 32'hDEADBEEF, 32'd4,
          13'b0_1_0_0_1_0_1_0_0_000_0, 32'd12, 32'd12);
    drive("lw_after_rst", 1'b0, 6'b100111, 32'd8, 32'd0, 32'd4,
          13'b1_1_1_1_1_0_1_0_0_000_0, 32'd12, 32'd0);
    drive("add", 1'b0, 6'b000000, 32'd5, 32'd7, 32'd100,
          13'b1_0_0_1_1_0_1_0_1_000_0, 32'd12, 32'd12);
    drive("sub", 1'b0, 6'b000010, 32'd3, 32'd5, 32'd0,
          13'b1_0_0_1_1_0_1_0_1_001_0, 32'hFFFFFFFE, 32'hFFFFFFFE);
    drive("ori", 1'b0, 6'b010000, 32'hF0, 32'h100, 32'h0F,
          13'b1_1_0_1_1_0_0_0_0_011_0, 32'hFF, 32'hFF);
    drive("and", 1'b0, 6'b010001, 32'hF0F0, 32'hFF00, 32'h0,
          13'b1_0_0_1_1_0_1_0_1_100_0, 32'hF000, 32'hF000);
    drive("or", 1'b0, 6'b010010, 32'hF000, 32'h000F, 32'h0,
          13'b1_0_0_1_1_0_1_0_1_011_0, 32'hF00F, 32'hF00F);
    drive("move", 1'b0, 6'b100000, 32'hCAFE, 32'h0, 32'h55,
          13'b1_0_0_1_1_0_1_0_1_000_0, 32'hCAFE, 32'hCAFE);
    drive("addi_wrap_zero", 1'b0, 6'b000001, 32'hFFFFFFFF, 32'h0, 32'd1,
          13'b1_1_0_1_1_0_1_0_0_000_1, 32'd0, 32'd0);
    drive("beq_taken", 1'b0, 6'b110000, 32'h1234, 32'h1234, 32'h0,
          13'b1_0_0_0_1_0_1_1_0_001_1, 32'd0, 32'd0);
    drive("beq_not_taken", 1'b0, 6'b110000, 32'h1234, 32'h1233, 32'h0,
          13'b1_0_0_0_1_0_1_0_0_001_0, 32'd1, 32'd1);
    drive("sw", 1'b0, 6'b100110, 32'd8, 32'hDEADBEEF, 32'd4,
          13'b1_1_0_0_1_1_1_0_0_000_0, 32'd12, 32'd12);
    drive("lw", 1'b0, 6'b100111, 32'd8, 32'd0, 32'd4,
          13'b1_1_1_1_1_0_1_0_0_000_0, 32'd12, 32'hDEADBEEF);
    // 269 = 4*67 + 1 -> word 67 mod 64 = 3, byte offset ignored.
    drive("lw_wrap", 1'b0, 6'b100111, 32'd265, 32'd0, 32'd4,
          13'b1_1_1_1_1_0_1_0_0_000_0, 32'd269, 32'hDEADBEEF);
    drive("sw_overwrite", 1'b0, 6'b100110, 32'd8, 32'h11111111, 32'd4,
          13'b1_1_0_0_1_1_1_0_0_000_0, 32'd12, 32'd12);
    drive("lw_overwrite", 1'b0, 6'b100111, 32'd4, 32'd0, 32'd8,
          13'b1_1_1_1_1_0_1_0_0_000_0, 32'd12, 32'h11111111);
    drive("halt", 1'b0, 6'b111111, 32'd0, 32'd0, 32'd0,
          13'b0_0_0_0_1_0_1_0_0_000_1, 32'd0, 32'd0);
    drive("undef_nop", 1'b0, 6'b000111, 32'd2, 32'd3, 32'd9,
          13'b1_0_0_0_1_0_0_0_0_000_0, 32'd5, 32'd5);
    drive("rst_sw2", 1'b1, 6'b100110, 32'd8, 32'h22222222, 32'd4,
          13'b0_1_0_0_1_0_1_0_0_000_0, 32'd12, 32'd12);
    drive("lw_after_rst2", 1'b0, 6'b100111, 32'd8, 32'd0, 32'd4,
          13'b1_1_1_1_1_0_1_0_0_000_0, 32'd12, 32'd0);
    drive("lw_other_after_rst", 1'b0, 6'b100111, 32'd0, 32'd0, 32'd40,
          13'b1_1_1_1_1_0_1_0_0_000_0, 32'd40, 32'd0);

    @(posedge clk);
    #1;
    vld = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
